// File: rtl/limn2600_interval_timer.sv
// Limn2600 interval timer: prescaled 32-bit down-counter on the CPU bus.
// Drives the system irq line from a latched pending flag.
module limn2600_interval_timer #(
  parameter logic [31:0] BASE     = 32'hF800_0000,
  parameter int          PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic          en;
  logic          ie;
  logic          auto;
  logic          pend;
  logic [31:0]   reload;
  logic [31:0]   count;
  logic [PW-1:0] presc;
  logic [31:0]   rd_val;

  logic       hit;
  logic [1:0] sel;
  logic       wr_ctrl;
  logic       wr_reload;
  logic       wr_count;
  logic       wr_status;
  logic       tick;
  logic       tick_ok;
  logic       expire;
  logic       unused_bits;

  assign unused_bits = ^addr[1:0];

  assign sel = addr[3:2];
  assign hit = (state == IDLE) && cs
             && (addr[31:4] == BASE[31:4]);

  assign wr_ctrl   = hit && we && (sel == 2'd0);
  assign wr_reload = hit && we && (sel == 2'd1);
  assign wr_count  = hit && we && (sel == 2'd2);
  assign wr_status = hit && we && (sel == 2'd3);

  // A CTRL or COUNT write in the tick cycle swallows that tick.
  assign tick    = en && (presc == PMAX);
  assign tick_ok = tick && !wr_ctrl && !wr_count;
  assign expire  = tick_ok && (count <= 32'd1);

  assign rdy = (state == RESP);
  assign irq = pend & ie;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (hit) state_nx = RESP;
      RESP:    state_nx = HOLD;
      HOLD:    if (!cs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    unique case (sel)
      2'd0: rd_val = {29'd0, auto, ie, en};
      2'd1: rd_val = reload;
      2'd2: rd_val = count;
      2'd3: rd_val = {31'd0, pend};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      auto     <= 1'b0;
      pend     <= 1'b0;
      reload   <= '0;
      count    <= '0;
      presc    <= '0;
      data_out <= '0;
    end else begin
      if (hit && !we) data_out <= rd_val;

      if (wr_ctrl || !en || tick) presc <= '0;
      else                        presc <= presc + PW'(1);

      if (tick_ok) begin
        if (count > 32'd1) begin
          count <= count - 32'd1;
        end else begin
          pend <= 1'b1;
          if (auto) begin
            count <= reload;
          end else begin
            count <= '0;
            en    <= 1'b0;
          end
        end
      end

      if (wr_ctrl) begin
        en   <= data_in[0];
        ie   <= data_in[1];
        auto <= data_in[2];
      end
      if (wr_reload) reload <= data_in;
      if (wr_count)  count  <= data_in;
      // An expiry in the same cycle keeps PEND set.
      if (wr_status && data_in[0] && !expire) pend <= 1'b0;
    end
  end

endmodule

// File: doc/limn2600_interval_timer.md
Name: limn2600_interval_timer

Overview:
Memory-mapped interval timer on the Limn2600 CPU bus, a sibling target to the SRAM: same cs/we/addr/data/rdy handshake. It is the producer of the system irq line. It counts down a prescaled 32-bit counter, latches a pending flag on expiry, and raises irq when interrupts are enabled. Software configures it through four word registers.

Parameters:
BASE, 32'hF800_0000, word-aligned base address; block decodes addr[31:4] == BASE[31:4].
PRESCALE, 4, clk cycles per count tick (>=1).

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
cs  input  1  bus cycle request from CPU
we  input  1  1 = write, 0 = read; sampled with cs
addr  input  32  byte address; addr[3:2] selects register, addr[1:0] ignored
data_in  input  32  write data from CPU
data_out  output  32  read data, valid while rdy=1
rdy  output  1  one-cycle completion strobe
irq  output  1  interrupt request, level

Behaviour:
- Registers by addr[3:2]:
  - 0 CTRL: bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
  - 1 RELOAD: 32 bits, R/W.
  - 2 COUNT: R/W current count.
  - 3 STATUS: bit0 PEND. Read returns PEND; writing 1 to bit0 clears it; writing 0 has no effect.
- Reset: CTRL=0, RELOAD=0, COUNT=0, PEND=0, prescaler=0, FSM=IDLE, rdy=0, data_out=0, irq=0.
- Bus FSM (IDLE, RESP, HOLD):
  - IDLE: if cs and address decodes, the write takes effect at this edge, or the read data is captured into data_out. Go to RESP. An undecoded cs is ignored and the FSM stays in IDLE.
  - RESP: rdy=1 for exactly this cycle and data_out is valid. Go to HOLD.
  - HOLD: rdy=0. Return to IDLE when cs=0. cs held high never causes a second access.
  - Latency: rdy is asserted in the cycle after cs is first sampled.
  - data_out holds its last value outside RESP.
- Prescaler:
  - When EN=1, the prescaler counts 0..PRESCALE-1. tick=1 in the cycle it equals PRESCALE-1, then it wraps to 0.
  - When EN=0, the prescaler is held at 0.
  - A CTRL write sets the prescaler to 0.
- Counting, on tick:
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT <= 1 (expiry): PEND <= 1. COUNT <= RELOAD if AUTO=1. If AUTO=0, COUNT <= 0 and EN <= 0.
  - AUTO=1 with RELOAD=0 or 1 expires on every tick.
- irq = PEND & IE, driven from registered state only (no combinational path from bus inputs).
- Simultaneous events:
  - A bus write to COUNT or CTRL in the same cycle as a tick: the write wins and that tick is discarded (no decrement, no expiry).
  - A STATUS write-1-clear in the same cycle as an expiry: set wins, PEND stays 1.
  - A RELOAD write in the same cycle as an auto-reload expiry: COUNT loads the old RELOAD value.
- Reset asserted in any FSM state or mid-count returns everything to reset values at that edge. An access in flight is dropped with no rdy.

Test Plan:
- Reset, then read CTRL, COUNT, STATUS -> each read returns 0. rdy pulses exactly 1 cycle, 1 cycle after cs. irq=0.
- Write COUNT=3, then CTRL=0b011 (EN, IE), PRESCALE=4 -> COUNT reads 2 after 4 clks and 1 after 8. PEND=1 and irq=1 at the 12th clk edge after the CTRL write. COUNT=0, EN reads 0.
- AUTO mode: RELOAD=5, COUNT=5, CTRL=0b111 -> irq rises every 20 clks. After write STATUS=1, irq drops the next cycle and re-asserts 20 clks after the previous expiry.
- Hold cs=1 and we=1 for 6 cycles writing COUNT=7 -> exactly one rdy pulse, COUNT=7. The next access is accepted only after cs drops.
- Write COUNT=9 on the exact tick cycle where COUNT=1 -> no expiry, PEND stays 0, COUNT=9. STATUS W1C on an expiry cycle -> PEND=1.
- Assert rst during RESP and during counting with COUNT=100 -> all outputs 0, no rdy. COUNT reads 0 on the next access.
